// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path: FSM states,
// opcodes, ALUOp classes and the ALUControl codes consumed by the datapath ALU.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's ALUOp class plus instruction
// fields onto the 3-bit ALUControl code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type from I-type, so addi never turns into sub
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RISC-V core: sequences each instruction over
// 3-5 cycles and drives every datapath select and write enable.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic [3:0] state_o
);

  state_t     state_q, state_d;
  logic       pc_update, branch;
  logic       ir_write, reg_write, mem_write;
  logic [1:0] alu_op;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = S_FETCH;
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: reg_write = 1'b1;
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset gates the enables combinationally so nothing is written once rst falls
  assign PCWrite  = rst & (pc_update | (branch & Zero));
  assign IRWrite  = rst & ir_write;
  assign RegWrite = rst & reg_write;
  assign MemWrite = rst & mem_write;
  assign state_o  = state_q;

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller: a driver pushes the
// expected per-cycle control words of each instruction, a monitor pops them.
module tb_multicycle_controller;

  localparam int W = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state_o;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .ALUControl(ALUControl), .state_o(state_o)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] pack(int st, logic pcw, logic adr, logic mw,
      logic irw, logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
      logic [1:0] imm, logic rw, logic [2:0] ac);
    logic [3:0] s4;
    s4 = st[3:0];
    return {s4, pcw, adr, mw, irw, rs, sa, sb, imm, rw, ac};
  endfunction

  function automatic logic [1:0] imm_of(logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  // Operation an R/I-type instruction asks the ALU to perform
  function automatic logic [2:0] arith_of(logic [6:0] o, logic [2:0] f3, logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [W-1:0] step_word(int st, logic [6:0] o, logic [2:0] f3,
      logic f7, logic z);
    logic [1:0] im;
    im = imm_of(o);
    case (st)
      0:  return pack(0,  1, 0, 0, 1, 2'b10, 2'b00, 2'b10, im, 0, 3'b000);
      1:  return pack(1,  0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, 0, 3'b000);
      2:  return pack(2,  0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 0, 3'b000);
      3:  return pack(3,  0, 1, 0, 0, 2'b00, 2'b00, 2'b00, im, 0, 3'b000);
      4:  return pack(4,  0, 0, 0, 0, 2'b01, 2'b00, 2'b00, im, 1, 3'b000);
      5:  return pack(5,  0, 1, 1, 0, 2'b00, 2'b00, 2'b00, im, 0, 3'b000);
      6:  return pack(6,  0, 0, 0, 0, 2'b00, 2'b10, 2'b00, im, 0, arith_of(o, f3, f7));
      7:  return pack(7,  0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 0, arith_of(o, f3, f7));
      8:  return pack(8,  0, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 1, 3'b000);
      9:  return pack(9,  1, 0, 0, 0, 2'b00, 2'b01, 2'b10, im, 0, 3'b000);
      default: return pack(10, z, 0, 0, 0, 2'b00, 2'b10, 2'b00, im, 0, 3'b001);
    endcase
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(string name, logic [31:0] got, logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, expv, $time);
    end
  endtask

  function automatic logic [W-1:0] observed();
    return {state_o, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
            ALUSrcB, ImmSrc, RegWrite, ALUControl};
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL ctrl_word got=%05h expected=<none> t=%0t", observed(), $time);
        end else begin
          e = exp_q.pop_front();
          chk("ctrl_word", 32'(observed()), 32'(e));
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge with the DUT in FETCH; zmode<0 randomizes Zero per cycle.
  task automatic run_instr(logic [6:0] o, logic [2:0] f3, logic f7, int zmode);
    int   path[$];
    logic zs[$];
    case (o)
      7'b0000011: path = '{0, 1, 2, 3, 4};
      7'b0100011: path = '{0, 1, 2, 5};
      7'b0110011: path = '{0, 1, 6, 8};
      7'b0010011: path = '{0, 1, 7, 8};
      7'b1101111: path = '{0, 1, 9, 8};
      7'b1100011: path = '{0, 1, 10};
      default:    path = '{0, 1};
    endcase
    op = o;
    funct3 = f3;
    funct7b5 = f7;
    foreach (path[i]) begin
      zs.push_back((zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode));
      exp_q.push_back(step_word(path[i], o, f3, f7, zs[i]));
    end
    foreach (path[i]) begin
      Zero = zs[i];
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [6:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 7'b0000011;
      1: return 7'b0100011;
      2: return 7'b0110011;
      3: return 7'b0010011;
      4: return 7'b1100011;
      5: return 7'b1101111;
      6: return 7'($urandom_range(0, 127));
      default: return 7'b0000000;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    op = 7'b0100011;
    Zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_enables", {28'd0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'd0);
      chk("rst_selects", {23'd0, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl},
          {23'd0, 1'b0, 2'b00, 2'b10, 2'b10, 3'b000});
      chk("rst_immsrc", 32'(ImmSrc), 32'(imm_of(op)));
      op = 7'b1101111;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;

    // directed instructions
    run_instr(7'b0000011, 3'b010, 1'b0, -1);  // lw
    run_instr(7'b0110011, 3'b000, 1'b1, -1);  // sub
    run_instr(7'b0110011, 3'b010, 1'b0, -1);  // slt
    run_instr(7'b0010011, 3'b000, 1'b1, -1);  // addi with funct7b5 set
    run_instr(7'b1100011, 3'b000, 1'b0, 1);   // beq taken
    run_instr(7'b1100011, 3'b000, 1'b0, 0);   // beq not taken
    run_instr(7'b0000000, 3'b000, 1'b0, -1);  // illegal
    run_instr(7'b0100011, 3'b010, 1'b0, -1);  // sw
    run_instr(7'b1101111, 3'b000, 1'b0, -1);  // jal

    for (int n = 0; n < 150; n++)
      run_instr(rand_op(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    mon_en = 1'b0;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    // sw aborted by reset in MEMADR
    op = 7'b0100011;
    funct3 = 3'b010;
    Zero = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("abort_pre_state", 32'(state_o), 32'd2);
    rst = 1'b0;
    #1;
    chk("abort_state", 32'(state_o), 32'd0);
    chk("abort_enables", {28'd0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("abort_hold_state", 32'(state_o), 32'd0);
      chk("abort_memwrite", 32'(MemWrite), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("refetch_state", 32'(state_o), 32'd0);
    chk("refetch_enables", {30'd0, IRWrite, PCWrite}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
